// File: rtl/serial_decoder.sv
// Byte-stream packet decoder: opcode byte plus 0/4/8 argument bytes (MSB first) -> cmd/addr/d_in.
// Optional inter-byte timeout enabled by defining SERIAL_DECODER_TIMEOUT_EN.
module serial_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        ctrlr_busy,
  output logic [3:0]  cmd,
  output logic [31:0] addr,
  output logic [31:0] d_in,
  output logic        out_valid,
  output logic        decode_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ISSUE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [3:0]  r_cmd;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_err;

  logic        w_legal;
  logic        w_no_arg;
  logic        w_has_data;
  logic        w_timeout;
  logic        w_err_set;
  logic        w_out_valid;

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("serial_decoder: TIMEOUT_CYCLES must be at least 2");
  end

  assign w_legal    = (rx_byte >= 8'h01) && (rx_byte <= 8'h09);
  assign w_no_arg   = (rx_byte >= 8'h01) && (rx_byte <= 8'h03);
  assign w_has_data = (r_cmd == 4'h6) || (r_cmd == 4'h7) || (r_cmd == 4'h9);

`ifdef SERIAL_DECODER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] r_tmo;

  // Counts idle cycles since the last argument byte; fires on the TIMEOUT_CYCLES-th one.
  assign w_timeout = ((r_state == S_ADDR) || (r_state == S_DATA)) && !rx_valid &&
                     (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (rx_valid || !((r_state == S_ADDR) || (r_state == S_DATA))) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_err_set   = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (w_legal) begin
            w_next = w_no_arg ? S_ISSUE : S_ADDR;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (w_timeout) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end else if (rx_valid && (r_cnt == 2'd3)) begin
          w_next = w_has_data ? S_DATA : S_ISSUE;
        end
      end
      S_DATA: begin
        if (w_timeout) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end else if (rx_valid && (r_cnt == 2'd3)) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_err_set = rx_valid;
        if (!ctrlr_busy) begin
          w_out_valid = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // addr/d_in are cleared on opcode acceptance so short packets report zero fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_cmd  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_err_set;
      case (r_state)
        S_IDLE: begin
          if (rx_valid && w_legal) begin
            r_cmd  <= rx_byte[3:0];
            r_addr <= '0;
            r_data <= '0;
            r_cnt  <= '0;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_addr <= {r_addr[23:0], rx_byte};
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_data <= {r_data[23:0], rx_byte};
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd        = r_cmd;
  assign addr       = r_addr;
  assign d_in       = r_data;
  assign out_valid  = w_out_valid;
  assign decode_err = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_decoder.sv
// Self-checking bench for serial_decoder: expected packets are queued as bytes are sent
// and compared when out_valid fires.
module tb_serial_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        ctrlr_busy;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        out_valid;
  logic        decode_err;
  logic        busy;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] d;
  } pkt_t;

  pkt_t sb[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   exp_err = 0;
  int   obs_err = 0;

  serial_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .ctrlr_busy (ctrlr_busy),
    .cmd        (cmd),
    .addr       (addr),
    .d_in       (d_in),
    .out_valid  (out_valid),
    .decode_err (decode_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_pkt(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    pkt_t p;
    p.c = c;
    p.a = a;
    p.d = d;
    sb.push_back(p);
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (decode_err) obs_err++;
      if (out_valid) begin
        check("ov_while_ctrlr_busy", {31'd0, ctrlr_busy}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          pkt_t p;
          p = sb.pop_front();
          check("cmd", {28'd0, cmd}, {28'd0, p.c});
          check("addr", addr, p.a);
          check("d_in", d_in, p.d);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pkt9 [9];
    reset      = 1'b1;
    rx_byte    = '0;
    rx_valid   = 1'b0;
    ctrlr_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd", {28'd0, cmd}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_d_in", d_in, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_decode_err", {31'd0, decode_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    idle(2);

    // 0-byte opcode, 1-cycle latency
    expect_pkt(4'h2, 32'h0, 32'h0);
    send_byte(8'h02);
    check("lat_resume", {31'd0, out_valid}, 32'd1);
    idle(3);

    // full 8-byte write packet, back to back
    expect_pkt(4'h6, 32'h0000_1000, 32'hDEAD_BEEF);
    send_byte(8'h06);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("lat_mem_wr", {31'd0, out_valid}, 32'd1);
    idle(3);

    // held off by ctrlr_busy; stray byte during wait is rejected
    ctrlr_busy = 1'b1;
    expect_pkt(4'h4, 32'h1122_3344, 32'h0);
    send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(8);
    exp_err++;
    send_byte(8'h01);
    check("issue_drop_err", {31'd0, decode_err}, 32'd1);
    idle(10);
    check("wait_busy", {31'd0, busy}, 32'd1);
    check("wait_cmd", {28'd0, cmd}, 32'h4);
    check("wait_addr", addr, 32'h1122_3344);
    check("wait_d_in", d_in, 32'h0);
    check("wait_pending", sb.size(), 32'd1);
    ctrlr_busy = 1'b0;
    idle(3);
    check("wait_released", sb.size(), 32'd0);

    // illegal opcode, then a legal one
    exp_err++;
    send_byte(8'hFF);
    check("ill_err", {31'd0, decode_err}, 32'd1);
    check("ill_busy", {31'd0, busy}, 32'd0);
    idle(2);
    exp_err++;
    send_byte(8'h00);
    check("ill00_busy", {31'd0, busy}, 32'd0);
    idle(2);
    expect_pkt(4'h3, 32'h0, 32'h0);
    send_byte(8'h03);
    idle(3);

    // reset mid-packet
    send_byte(8'h07);
    send_byte(8'hAA);
    reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_addr", addr, 32'd0);
    idle(2);
    reset = 1'b0;
    idle(1);
    expect_pkt(4'h5, 32'h0000_0008, 32'h0);
    send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    check("lat_reg_rd", {31'd0, out_valid}, 32'd1);
    idle(3);

    // argument bytes separated by idle cycles
    pkt9 = '{8'h09, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
    expect_pkt(4'h9, 32'hA1B2_C3D4, 32'h0102_0304);
    for (int i = 0; i < 9; i++) begin
      send_byte(pkt9[i]);
      if (i < 8) idle(2);
    end
    check("lat_gapped", {31'd0, out_valid}, 32'd1);
    idle(3);

`ifdef SERIAL_DECODER_TIMEOUT_EN
    send_byte(8'h04);
    send_byte(8'h12);
    idle(99);
    check("tmo_not_yet", {31'd0, busy}, 32'd1);
    exp_err++;
    idle(1);
    check("tmo_err", {31'd0, decode_err}, 32'd1);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    idle(2);
    expect_pkt(4'h1, 32'h0, 32'h0);
    send_byte(8'h01);
    idle(3);
`else
    send_byte(8'h04);
    send_byte(8'h12);
    idle(150);
    check("no_tmo_busy", {31'd0, busy}, 32'd1);
    expect_pkt(4'h4, 32'h1234_5678, 32'h0);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    idle(3);
`endif

    check("sb_empty", sb.size(), 32'd0);
    check("err_count", obs_err, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_decoder.md
SERIAL_DECODER -- requirements
Module: serial_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, inter-byte timeout in clk cycles (20 ms at 50 MHz).
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_byte  in  8  byte from UART receiver.
REQ-005 SHALL have port rx_valid  in  1  one-cycle strobe; rx_byte valid this cycle.
REQ-006 SHALL have port ctrlr_busy  in  1  downstream controller FSM cannot accept a command.
REQ-007 SHALL have port cmd  out  4  decoded command code.
REQ-008 SHALL have port addr  out  32  decoded address.
REQ-009 SHALL have port d_in  out  32  decoded write data.
REQ-010 SHALL have port out_valid  out  1  one-cycle strobe; cmd/addr/d_in valid.
REQ-011 SHALL have port decode_err  out  1  one-cycle strobe on a rejected byte, opcode or packet.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL frame packets as one opcode byte, then 0/4/8 argument bytes, MSB first: address word, then data word.
REQ-014 SHALL set argument length by opcode:
- 0x01 pause, 0x02 resume, 0x03 reset: 0 bytes.
- 0x04 mem_rd, 0x05 reg_rd, 0x08 mem_rd_byte: 4 bytes (addr).
- 0x06 mem_wr, 0x07 reg_wr, 0x09 mem_wr_byte: 8 bytes (addr, data).
REQ-015 SHALL implement states IDLE, ADDR, DATA, ISSUE.
REQ-016 SHALL, in IDLE on rx_valid with a legal opcode, latch cmd = rx_byte[3:0] and go to ADDR (4/8-byte opcodes) or ISSUE (0-byte opcodes).
REQ-017 SHALL, in IDLE on rx_valid with an illegal opcode (0x00, 0x0A-0xFF), pulse decode_err the next cycle and remain in IDLE.
REQ-018 SHALL shift bytes into addr as addr <= {addr[23:0], rx_byte}, using a 2-bit byte counter; after the 4th byte go to DATA (8-byte opcodes) or ISSUE.
REQ-019 SHALL shift 4 bytes into d_in the same way in DATA, then go to ISSUE.
REQ-020 SHALL clear d_in to 0 when a packet without data is accepted.
REQ-021 SHALL, in ISSUE, assert out_valid for exactly one cycle, in the first cycle with ctrlr_busy=0, then return to IDLE.
REQ-022 SHALL give a latency of 1 cycle from the final byte's rx_valid to out_valid when ctrlr_busy=0.
REQ-023 SHALL hold cmd/addr/d_in stable from entry to ISSUE until the next legal opcode is accepted.
REQ-024 SHALL, on rx_valid while in ISSUE, drop the byte, pulse decode_err, and stay in ISSUE.
REQ-025 SHALL NOT shift an argument byte while rx_valid is low; an argument byte is consumed only on an rx_valid cycle.
REQ-026 SHALL wrap the byte counter 3->0 on each word boundary; it SHALL never index beyond 4 bytes per word.

Reset
REQ-027 SHALL, on reset assertion, immediately go to IDLE and clear the byte counter and timeout counter, with cmd=0, addr=0, d_in=0, out_valid=0, decode_err=0, busy=0.
REQ-028 SHALL discard a partial packet on reset mid-packet; the first rx_valid after release SHALL be decoded as an opcode.

Configuration
REQ-029 SHALL implement an inter-byte timeout when macro SERIAL_DECODER_TIMEOUT_EN is defined:
- Counter resets on every rx_valid and counts in ADDR/DATA.
- On reaching TIMEOUT_CYCLES it SHALL pulse decode_err, go to IDLE, and discard the packet.
REQ-030 SHALL, without SERIAL_DECODER_TIMEOUT_EN, contain no timeout counter; ADDR/DATA wait indefinitely.

Verification
REQ-031 SHALL pass: bytes 0x02 -> one out_valid, cmd=0x2, addr=0, d_in=0, 1 cycle after the byte.
REQ-032 SHALL pass: bytes 06 00 00 10 00 DE AD BE EF with ctrlr_busy=0 -> one out_valid, cmd=0x6, addr=0x00001000, d_in=0xDEADBEEF.
REQ-033 SHALL pass: bytes 04 11 22 33 44 with ctrlr_busy=1 for 20 cycles -> no out_valid until ctrlr_busy falls, then one pulse with addr=0x11223344; a byte 0x01 sent during the wait -> decode_err pulse, no change to outputs.
REQ-034 SHALL pass: byte 0xFF -> decode_err pulse, busy stays 0; following 0x03 -> out_valid, cmd=0x3.
REQ-035 SHALL pass: bytes 07 AA, then reset pulse, then 05 00 00 00 08 -> out_valid, cmd=0x5, addr=0x00000008, with no trace of 0xAA.
REQ-036 SHALL pass, with SERIAL_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=100: bytes 04 12, then idle for 100 cycles -> decode_err pulse, busy=0; following 0x01 -> out_valid, cmd=0x1.
